// File: rtl/ro_puf_pkg.sv
// Shared state encoding, sizing helpers and defaults for the ring-oscillator PUF arbiter/counter.
package ro_puf_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      COUNT   = 3'd2,
      COMPARE = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam int unsigned THRESH_DEFAULT = 8;

   // Width of a challenge index for a bank of num_ro oscillators.
   function automatic int unsigned sel_width(input int unsigned num_ro);
      return (num_ro < 2) ? 1 : $clog2(num_ro);
   endfunction

   // Width of the window counter; must hold WINDOW-1.
   function automatic int unsigned win_width(input int unsigned window);
      return (window < 1) ? 1 : $clog2(window + 1);
   endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// One RO channel: synchroniser, rising-edge detect and a saturating edge counter.
module ro_edge_counter #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ro,
   input  logic             clr,
   input  logic             cnt_en,
   input  logic             freeze,
   output logic [CNT_W-1:0] count,
   output logic             sat_c
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   lvl_c;
   logic                   rise_c;

   assign lvl_c  = sync_q[SYNC_STAGES-1];
   assign rise_c = lvl_c & ~prev_q;
   assign sat_c  = &count;

   // prev_q tracks the synchronised level every cycle, so loading it during
   // clr (and while paused) never produces a stale edge later.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         count  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ro};
         prev_q <= lvl_c;
         if (clr) begin
            count <= '0;
         end else if (cnt_en && !freeze && rise_c && !sat_c) begin
            count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/ro_puf_arbiter_counter.sv
// RO-PUF arbiter: counts edges of two challenge-selected ROs over a window and compares them.
// Optional macro RO_PUF_RELIABILITY_EN adds THRESH and an 'unreliable' flag output.
module ro_puf_arbiter_counter
   import ro_puf_pkg::*;
#(
   parameter int unsigned NUM_RO      = 16,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned WINDOW      = 4096,
   parameter int unsigned SYNC_STAGES = 2
`ifdef RO_PUF_RELIABILITY_EN
   ,
   parameter int unsigned THRESH      = THRESH_DEFAULT
`endif
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      start,
   input  logic [$clog2(NUM_RO)-1:0] sel_a,
   input  logic [$clog2(NUM_RO)-1:0] sel_b,
   input  logic [NUM_RO-1:0]         ro_in,
   output logic                      busy,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic                      resp_bit,
   output logic                      tie,
   output logic                      saturated,
   output logic [CNT_W-1:0]          count_a,
   output logic [CNT_W-1:0]          count_b
`ifdef RO_PUF_RELIABILITY_EN
   ,
   output logic                      unreliable
`endif
);

   localparam int unsigned SEL_W = sel_width(NUM_RO);
   localparam int unsigned WIN_W = win_width(WINDOW);

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   sel_a_q, sel_a_d;
   logic [SEL_W-1:0]   sel_b_q, sel_b_d;
   logic [WIN_W-1:0]   win_q, win_d;
   logic               busy_d, resp_valid_d, resp_bit_d, tie_d, saturated_d;
   logic [CNT_W-1:0]   count_a_d, count_b_d;

   logic               ro_a_c, ro_b_c;
   logic               clr_c, cnt_en_c, freeze_c;
   logic [CNT_W-1:0]   cnt_a, cnt_b;
   logic               sat_a_c, sat_b_c;

   // Pair mux ahead of the synchronisers; out-of-range indices read channel 0.
   always_comb begin
      ro_a_c = ro_in[0];
      ro_b_c = ro_in[0];
      for (int unsigned i = 1; i < NUM_RO; i++) begin
         if (sel_a_q == SEL_W'(i)) ro_a_c = ro_in[i];
         if (sel_b_q == SEL_W'(i)) ro_b_c = ro_in[i];
      end
   end

   assign freeze_c = sat_a_c | sat_b_c;

   ro_edge_counter #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_cnt_a (
      .clk    (clk),
      .reset  (reset),
      .ro     (ro_a_c),
      .clr    (clr_c),
      .cnt_en (cnt_en_c),
      .freeze (freeze_c),
      .count  (cnt_a),
      .sat_c  (sat_a_c)
   );

   ro_edge_counter #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_cnt_b (
      .clk    (clk),
      .reset  (reset),
      .ro     (ro_b_c),
      .clr    (clr_c),
      .cnt_en (cnt_en_c),
      .freeze (freeze_c),
      .count  (cnt_b),
      .sat_c  (sat_b_c)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      sel_a_d     = sel_a_q;
      sel_b_d     = sel_b_q;
      win_d       = win_q;
      resp_bit_d  = resp_bit;
      tie_d       = tie;
      saturated_d = saturated;
      count_a_d   = count_a;
      count_b_d   = count_b;
      clr_c       = 1'b0;
      cnt_en_c    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && enable) begin
               state_d = CLEAR;
               sel_a_d = SEL_W'(sel_a);
               sel_b_d = SEL_W'(sel_b);
            end
         end
         CLEAR: begin
            clr_c   = 1'b1;
            win_d   = '0;
            state_d = COUNT;
         end
         COUNT: begin
            cnt_en_c = enable;
            if (freeze_c) begin
               state_d = COMPARE;
            end else if (enable) begin
               if (win_q == WIN_W'(WINDOW - 1)) state_d = COMPARE;
               else                             win_d   = win_q + WIN_W'(1);
            end
         end
         COMPARE: begin
            resp_bit_d  = (cnt_a > cnt_b);
            tie_d       = (cnt_a == cnt_b);
            saturated_d = freeze_c;
            count_a_d   = cnt_a;
            count_b_d   = cnt_b;
            state_d     = DONE;
         end
         DONE: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d       = (state_d != IDLE);
      resp_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         sel_a_q    <= '0;
         sel_b_q    <= '0;
         win_q      <= '0;
         busy       <= 1'b0;
         resp_valid <= 1'b0;
         resp_bit   <= 1'b0;
         tie        <= 1'b0;
         saturated  <= 1'b0;
         count_a    <= '0;
         count_b    <= '0;
      end else begin
         state_q    <= state_d;
         sel_a_q    <= sel_a_d;
         sel_b_q    <= sel_b_d;
         win_q      <= win_d;
         busy       <= busy_d;
         resp_valid <= resp_valid_d;
         resp_bit   <= resp_bit_d;
         tie        <= tie_d;
         saturated  <= saturated_d;
         count_a    <= count_a_d;
         count_b    <= count_b_d;
      end
   end

`ifdef RO_PUF_RELIABILITY_EN
   localparam int unsigned DIFF_W = CNT_W + 1;

   logic [DIFF_W-1:0] diff_c;
   logic              unreliable_d;

   // Magnitude of the count difference, one bit wider than the counters.
   always_comb begin
      if (cnt_a >= cnt_b) diff_c = {1'b0, cnt_a} - {1'b0, cnt_b};
      else                diff_c = {1'b0, cnt_b} - {1'b0, cnt_a};
      unreliable_d = unreliable;
      if (state_q == COMPARE) unreliable_d = (diff_c < DIFF_W'(THRESH)) | freeze_c;
   end

   always_ff @(posedge clk) begin
      if (reset) unreliable <= 1'b0;
      else       unreliable <= unreliable_d;
   end
`endif

endmodule

// File: tb/tb_ro_puf_arbiter_counter.sv
// Scoreboard bench for ro_puf_arbiter_counter: small bank, short window, narrow counters.
module tb_ro_puf_arbiter_counter;

   localparam int unsigned NUM_RO      = 4;
   localparam int unsigned CNT_W       = 4;
   localparam int unsigned WINDOW      = 100;
   localparam int unsigned SYNC_STAGES = 2;

   logic              clk = 1'b0;
   logic              reset, enable, start, resp_ready;
   logic [1:0]        sel_a, sel_b;
   logic [NUM_RO-1:0] ro_in;
   logic              busy, resp_valid, resp_bit, tie, saturated;
   logic [CNT_W-1:0]  count_a, count_b;
`ifdef RO_PUF_RELIABILITY_EN
   logic              unreliable;
`endif

   always #5 clk = ~clk;

   ro_puf_arbiter_counter #(
      .NUM_RO      (NUM_RO),
      .CNT_W       (CNT_W),
      .WINDOW      (WINDOW),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .start      (start),
      .sel_a      (sel_a),
      .sel_b      (sel_b),
      .ro_in      (ro_in),
      .busy       (busy),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_bit   (resp_bit),
      .tie        (tie),
      .saturated  (saturated),
      .count_a    (count_a),
      .count_b    (count_b)
`ifdef RO_PUF_RELIABILITY_EN
      ,
      .unreliable (unreliable)
`endif
   );

   typedef struct {
      int s_cyc;
      int lat_lo, lat_hi;
      int a_lo, a_hi, b_lo, b_hi;
      int rbit, tie, sat;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   hp   [NUM_RO];
   int   hcnt [NUM_RO];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int lo, input int hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
      end
   endtask

   // RO model: channel i toggles every hp[i] clocks (0 = static).
   initial begin
      ro_in = '0;
      for (int i = 0; i < NUM_RO; i++) begin hp[i] = 0; hcnt[i] = 0; end
      forever begin
         @(negedge clk);
         for (int i = 0; i < NUM_RO; i++) begin
            if (hp[i] != 0) begin
               hcnt[i]++;
               if (hcnt[i] >= hp[i]) begin
                  hcnt[i]  = 0;
                  ro_in[i] = ~ro_in[i];
               end
            end
         end
      end
   end

   // Monitor: samples mid-cycle, pops the scoreboard when a response appears.
   initial begin : monitor
      bit   prev_rst = 1'b0;
      bit   prev_hs  = 1'b0;
      bit   in_done  = 1'b0;
      int   ha, hb, hbit, htie, hsat;
      exp_t e;
      forever begin
         @(negedge clk);
         if (prev_rst) begin
            chk("rst_busy",   int'(busy),       0, 0);
            chk("rst_valid",  int'(resp_valid), 0, 0);
            chk("rst_count_a", int'(count_a),   0, 0);
            chk("rst_count_b", int'(count_b),   0, 0);
            chk("rst_resp_bit", int'(resp_bit), 0, 0);
            chk("rst_tie",    int'(tie),        0, 0);
            chk("rst_sat",    int'(saturated),  0, 0);
            in_done = 1'b0;
         end else if (prev_hs) begin
            chk("post_hs_valid", int'(resp_valid), 0, 0);
            chk("post_hs_busy",  int'(busy),       0, 0);
            in_done = 1'b0;
         end else if (resp_valid && !in_done) begin
            in_done = 1'b1;
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_resp: got resp_valid=1, want no pending response");
            end else begin
               e = sbq.pop_front();
               chk("latency",   cyc - e.s_cyc,     e.lat_lo, e.lat_hi);
               chk("count_a",   int'(count_a),     e.a_lo,   e.a_hi);
               chk("count_b",   int'(count_b),     e.b_lo,   e.b_hi);
               chk("resp_bit",  int'(resp_bit),    e.rbit,   e.rbit);
               chk("tie",       int'(tie),         e.tie,    e.tie);
               chk("saturated", int'(saturated),   e.sat,    e.sat);
               chk("done_busy", int'(busy),        1,        1);
               if (e.tie == 1) chk("tie_counts_equal", int'(count_a), int'(count_b), int'(count_b));
`ifdef RO_PUF_RELIABILITY_EN
               chk("unreliable", int'(unreliable), 1, 1);
`endif
            end
            ha   = int'(count_a);
            hb   = int'(count_b);
            hbit = int'(resp_bit);
            htie = int'(tie);
            hsat = int'(saturated);
         end else if (resp_valid && in_done) begin
            chk("hold_count_a", int'(count_a),   ha,   ha);
            chk("hold_count_b", int'(count_b),   hb,   hb);
            chk("hold_resp_bit", int'(resp_bit), hbit, hbit);
            chk("hold_tie",     int'(tie),       htie, htie);
            chk("hold_sat",     int'(saturated), hsat, hsat);
            chk("hold_busy",    int'(busy),      1,    1);
         end else if (sbq.size() != 0 && (cyc - sbq[0].s_cyc) > sbq[0].lat_hi + 5) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: got no resp_valid after %0d cycles, want within %0d",
                     cyc - sbq[0].s_cyc, sbq[0].lat_hi);
            sbq.delete(0);
         end
         prev_rst = reset;
         prev_hs  = resp_valid && resp_ready && !reset;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int sa, input int sb, input int lat_lo, input int lat_hi,
                        input int a_lo, input int a_hi, input int b_lo, input int b_hi,
                        input int rbit, input int t, input int sat);
      exp_t e;
      tick();
      sel_a = 2'(sa);
      sel_b = 2'(sb);
      start = 1'b1;
      e.s_cyc  = cyc;
      e.lat_lo = lat_lo; e.lat_hi = lat_hi;
      e.a_lo = a_lo; e.a_hi = a_hi; e.b_lo = b_lo; e.b_hi = b_hi;
      e.rbit = rbit; e.tie = t; e.sat = sat;
      sbq.push_back(e);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((sbq.size() != 0 || busy) && n < budget) begin tick(); n++; end
      if (n >= budget) begin
         $display("FAIL wait_idle: got busy after %0d cycles, want idle", n);
         $fatal(1, "bench stalled");
      end
      repeat (3) tick();
   endtask

   initial begin
      reset      = 1'b1;
      enable     = 1'b1;
      start      = 1'b0;
      resp_ready = 1'b1;
      sel_a      = '0;
      sel_b      = '0;
      repeat (3) tick();
      reset = 1'b0;
      hp[0] = 2;
      hp[1] = 4;
      hp[2] = 6;
      hp[3] = 5;
      repeat (5) tick();

      // Nominal: ~12.5 vs ~8.3 rising edges in 100 cycles; response 103 cycles after start.
      issue(1, 2, 103, 103, 11, 14, 7, 10, 1, 0, 0);
      wait_idle(400);

      // Fast RO on A saturates a 4-bit counter well before the window ends.
      issue(0, 2, 50, 80, 15, 15, 3, 7, 1, 0, 1);
      wait_idle(400);

      // Same oscillator on both sides, with backpressure and a start during DONE.
      resp_ready = 1'b0;
      issue(3, 3, 103, 103, 9, 12, 9, 12, 0, 1, 0);
      begin
         int n = 0;
         while (!resp_valid && n < 300) begin tick(); n++; end
         if (n >= 300) begin
            $display("FAIL bp_wait: got resp_valid=0 after %0d cycles, want 1", n);
            $fatal(1, "bench stalled");
         end
      end
      repeat (10) tick();
      sel_a = 2'd1;
      sel_b = 2'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      resp_ready = 1'b1;
      start      = 1'b1;
      tick();
      start = 1'b0;
      wait_idle(400);

      // Enable dropped for 50 cycles mid-COUNT stretches the measurement to 150 cycles.
      hp[0] = 10;
      repeat (3) tick();
      issue(3, 0, 153, 153, 8, 13, 3, 7, 1, 0, 0);
      repeat (30) tick();
      enable = 1'b0;
      repeat (50) tick();
      enable = 1'b1;
      wait_idle(400);

      // Reset mid-COUNT discards the measurement and clears all outputs.
      tick();
      sel_a = 2'd1;
      sel_b = 2'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (30) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (5) tick();
      wait_idle(400);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
